// File: rtl/subword_rmw_pkg.sv
// Shared types and helpers for the sub-word load/store engine.
package subword_rmw_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // True when the access is wider than a memory word or not naturally aligned.
  function automatic logic access_err(input logic [7:0] addr_lo, input logic [1:0] size,
                                      input int lanes);
    logic [7:0] mask;
    mask = 8'((32'd1 << size) - 32'd1);
    return (int'(32'd1 << size) > lanes) || ((addr_lo & mask) != 8'd0);
  endfunction

endpackage

// File: rtl/lane_merge.sv
// Combinational lane logic: merges store bytes into an old word and
// extracts/extends the addressed field of that word for loads.
module lane_merge
  import subword_rmw_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int LANES  = DATA_W / 8,
  localparam int OFS_W  = $clog2(LANES)
) (
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] wdata,
  input  logic [OFS_W-1:0]  ofs,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] merged,
  output logic [DATA_W-1:0] load_val
);

  int                nbytes;
  logic [OFS_W+2:0]  bit_ofs;
  logic [DATA_W-1:0] wshift;
  logic [DATA_W-1:0] rshift;
  logic              sign_bit;

  always_comb begin
    nbytes = LANES;
    case (size)
      SZ_BYTE:  nbytes = 1;
      SZ_HALF:  nbytes = 2;
      SZ_WORD:  nbytes = 4;
      SZ_DWORD: nbytes = 8;
    endcase
    if (nbytes > LANES) nbytes = LANES;

    bit_ofs = {ofs, 3'b000};
    wshift  = wdata << bit_ofs;
    rshift  = old_word >> bit_ofs;

    // Sign comes from the top bit of the field once it sits at bit 0.
    sign_bit = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (i == nbytes - 1) sign_bit = rshift[8*i+7];
    end

    merged   = old_word;
    load_val = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i >= int'(ofs) && i < int'(ofs) + nbytes) merged[8*i +: 8] = wshift[8*i +: 8];
      if (i < nbytes)    load_val[8*i +: 8] = rshift[8*i +: 8];
      else if (sign_ext) load_val[8*i +: 8] = {8{sign_bit}};
    end
  end

endmodule

// File: rtl/subword_rmw.sv
// Handshaked byte/half/word load-store unit in front of a word-wide memory
// without byte enables; sub-word stores are performed as read-modify-write.
module subword_rmw
  import subword_rmw_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output state_t            dbg_state
);

  localparam int LANES = DATA_W / 8;
  localparam int OFS_W = $clog2(LANES);

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both 1; the response is the single cycle with resp_valid = 1
  // and has no back-pressure. Memory strobes hold until the mem_ack edge.

  state_t            state, state_nxt;
  logic              we_q;
  logic              signed_q;
  logic [1:0]        size_q;
  logic [OFS_W-1:0]  ofs_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] word_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  logic              req_err;
  logic              full_word;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] load_val;

  assign req_err   = access_err(8'(req_addr[OFS_W-1:0]), req_size, LANES);
  assign full_word = ((32'd1 << req_size) == 32'(LANES));

  lane_merge #(.DATA_W(DATA_W)) u_lane_merge (
    .old_word (mem_rdata),
    .wdata    (word_q),
    .ofs      (ofs_q),
    .size     (size_q),
    .sign_ext (signed_q),
    .merged   (merged),
    .load_val (load_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_err)                state_nxt = ST_RESP;
          else if (req_we && full_word) state_nxt = ST_WR;
          else                        state_nxt = ST_RD;
        end
      end
      ST_RD:   if (mem_ack) state_nxt = we_q ? ST_WR : ST_RESP;
      ST_WR:   if (mem_ack) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // word_q carries the store data until the read returns, then the merged word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= SZ_BYTE;
      ofs_q    <= '0;
      addr_q   <= '0;
      word_q   <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            signed_q <= req_signed;
            size_q   <= req_size;
            ofs_q    <= req_addr[OFS_W-1:0];
            addr_q   <= {req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
            word_q   <= req_wdata;
            err_q    <= req_err;
            rdata_q  <= '0;
          end
        end
        ST_RD: begin
          if (mem_ack) begin
            if (we_q) word_q  <= merged;
            else      rdata_q <= load_val;
          end
        end
        ST_RESP: begin
          err_q   <= 1'b0;
          rdata_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = rst_n && (state == ST_IDLE);
  assign mem_rd     = (state == ST_RD);
  assign mem_wr     = (state == ST_WR);
  assign resp_valid = (state == ST_RESP);
  assign resp_err   = err_q;
  assign resp_rdata = rdata_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = word_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_subword_rmw.sv
// Directed bench for subword_rmw: a 32-bit and a 64-bit instance behind one
// shared request bus, a word memory model with programmable ack delay, and a
// response scoreboard.
module tb_subword_rmw;
  import subword_rmw_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel64 = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        mem_ack_i = 1'b0;
  logic [63:0] mem_rdata_i = '0;

  logic        ready32, rv32, err32, mrd32, mwr32;
  logic [31:0] rdata32, maddr32, mwdata32;
  state_t      dbg32;
  logic        ready64, rv64, err64, mrd64, mwr64;
  logic [63:0] rdata64, mwdata64;
  logic [31:0] maddr64;
  state_t      dbg64;

  subword_rmw #(.DATA_W(32), .ADDR_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid && !sel64), .req_ready(ready32), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]),
    .resp_valid(rv32), .resp_err(err32), .resp_rdata(rdata32),
    .mem_addr(maddr32), .mem_rd(mrd32), .mem_wr(mwr32), .mem_wdata(mwdata32),
    .mem_rdata(mem_rdata_i[31:0]), .mem_ack(mem_ack_i && !sel64), .dbg_state(dbg32)
  );

  subword_rmw #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid && sel64), .req_ready(ready64), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(rv64), .resp_err(err64), .resp_rdata(rdata64),
    .mem_addr(maddr64), .mem_rd(mrd64), .mem_wr(mwr64), .mem_wdata(mwdata64),
    .mem_rdata(mem_rdata_i), .mem_ack(mem_ack_i && sel64), .dbg_state(dbg64)
  );

  logic        cur_ready, cur_rv, cur_err, cur_mrd, cur_mwr;
  logic [63:0] cur_rdata, cur_mwdata;
  logic [31:0] cur_maddr;
  state_t      cur_state;
  assign cur_ready  = sel64 ? ready64 : ready32;
  assign cur_rv     = sel64 ? rv64 : rv32;
  assign cur_err    = sel64 ? err64 : err32;
  assign cur_mrd    = sel64 ? mrd64 : mrd32;
  assign cur_mwr    = sel64 ? mwr64 : mwr32;
  assign cur_rdata  = sel64 ? rdata64 : {32'b0, rdata32};
  assign cur_mwdata = sel64 ? mwdata64 : {32'b0, mwdata32};
  assign cur_maddr  = sel64 ? maddr64 : maddr32;
  assign cur_state  = sel64 ? dbg64 : dbg32;

  // ---------------- memory model ----------------
  logic [63:0] mem [logic [31:0]];
  int rd_wait = 0;
  int wr_wait = 0;

  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      mem_ack_i = 1'b0;
      if (!rst_n) cnt = 0;
      else if (cur_mrd || cur_mwr) begin
        if (cnt < (cur_mrd ? rd_wait : wr_wait)) cnt++;
        else begin
          mem_ack_i = 1'b1;
          cnt = 0;
          if (cur_mrd) mem_rdata_i = mem.exists(cur_maddr) ? mem[cur_maddr] : 64'h0;
          else         mem[cur_maddr] = cur_mwdata;
        end
      end else cnt = 0;
    end
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [64:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request; the k-counts are edges after the accept edge T.
  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic sgn, input logic [31:0] addr, input logic [63:0] wdata,
                        input logic exp_err, input logic [63:0] exp_rdata,
                        input int exp_resp_k, input int exp_rd_k, input int exp_rd_n,
                        input int exp_wr_k, input logic [63:0] exp_wdata,
                        input logic [31:0] exp_maddr);
    int k, resp_k, rd_first, rd_n, wr_first, both;
    logic got, addr_stable;
    logic [31:0] rd_addr, wr_addr;
    logic [63:0] wr_data;
    logic [64:0] ent;
    k = 0; resp_k = 0; rd_first = 0; rd_n = 0; wr_first = 0; both = 0;
    got = 1'b0; addr_stable = 1'b1;
    rd_addr = 32'hFFFF_FFFF; wr_addr = 32'hFFFF_FFFF; wr_data = 64'hx;
    exp_q.push_back({exp_err, exp_rdata});

    @(negedge clk);
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    for (int w = 0; w < 20 && !cur_ready; w++) @(negedge clk);
    chk({tag, "_ready"}, 64'(cur_ready), 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;

    while (k < 60 && !got) begin
      @(negedge clk);
      k++;
      if (cur_mrd && cur_mwr) both++;
      if (cur_mrd) begin
        if (rd_n == 0) begin rd_first = k; rd_addr = cur_maddr; end
        else if (cur_maddr !== rd_addr) addr_stable = 1'b0;
        rd_n++;
      end
      if (cur_mwr && wr_first == 0) begin
        wr_first = k; wr_addr = cur_maddr; wr_data = cur_mwdata;
      end
      if (cur_rv) begin
        got = 1'b1;
        resp_k = k;
        ent = exp_q.pop_front();
        chk({tag, "_err"}, 64'(cur_err), 64'(ent[64]));
        chk({tag, "_rdata"}, cur_rdata, ent[63:0]);
      end
    end
    if (!got && exp_q.size() > 0) ent = exp_q.pop_front();
    chk({tag, "_resp_seen"}, 64'(got), 64'd1);
    chk({tag, "_resp_cycle"}, 64'(resp_k), 64'(exp_resp_k));
    chk({tag, "_rd_first"}, 64'(rd_first), 64'(exp_rd_k));
    chk({tag, "_rd_cycles"}, 64'(rd_n), 64'(exp_rd_n));
    chk({tag, "_wr_first"}, 64'(wr_first), 64'(exp_wr_k));
    chk({tag, "_rd_wr_overlap"}, 64'(both), 64'd0);
    if (exp_rd_n != 0) begin
      chk({tag, "_rd_addr"}, 64'(rd_addr), 64'(exp_maddr));
      chk({tag, "_rd_addr_stable"}, 64'(addr_stable), 64'd1);
    end
    if (exp_wr_k != 0) begin
      chk({tag, "_wr_addr"}, 64'(wr_addr), 64'(exp_maddr));
      chk({tag, "_wr_data"}, wr_data, exp_wdata);
    end
    @(negedge clk);
    chk({tag, "_pulse_end"}, 64'(cur_rv), 64'd0);
    chk({tag, "_idle"}, 64'(cur_state), 64'(ST_IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [63:0] exp_word;
    int resp_seen;

    mem[32'h1000] = 64'h1122_3344;
    mem[32'h2000] = 64'h8001_FFFF;

    // reset values
    #12;
    chk("rst_ready32", 64'(ready32), 64'd0);
    chk("rst_ready64", 64'(ready64), 64'd0);
    chk("rst_resp_valid", 64'(rv32), 64'd0);
    chk("rst_mem_rd", 64'(mrd32), 64'd0);
    chk("rst_mem_wr", 64'(mwr32), 64'd0);
    chk("rst_mem_addr", 64'(maddr32), 64'd0);
    chk("rst_mem_wdata", 64'(mwdata32), 64'd0);
    chk("rst_resp_rdata", 64'(rdata32), 64'd0);
    chk("rst_state", 64'(dbg32), 64'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_release_ready", 64'(ready32), 64'd1);

    // 32-bit directed cases
    do_req("byte_store", 1'b1, SZ_BYTE, 1'b0, 32'h1002, 64'hAB, 1'b0, 64'h0,
           3, 1, 1, 2, 64'h11AB_3344, 32'h1000);
    do_req("half_load_s", 1'b0, SZ_HALF, 1'b1, 32'h2002, 64'h0, 1'b0, 64'hFFFF_8001,
           2, 1, 1, 0, 64'h0, 32'h2000);
    do_req("half_load_u", 1'b0, SZ_HALF, 1'b0, 32'h2002, 64'h0, 1'b0, 64'h0000_8001,
           2, 1, 1, 0, 64'h0, 32'h2000);
    do_req("byte_load_s", 1'b0, SZ_BYTE, 1'b1, 32'h2000, 64'h0, 1'b0, 64'hFFFF_FFFF,
           2, 1, 1, 0, 64'h0, 32'h2000);
    do_req("word_load_s", 1'b0, SZ_WORD, 1'b1, 32'h2000, 64'h0, 1'b0, 64'h8001_FFFF,
           2, 1, 1, 0, 64'h0, 32'h2000);
    do_req("word_store", 1'b1, SZ_WORD, 1'b0, 32'h3000, 64'hDEAD_BEEF, 1'b0, 64'h0,
           2, 0, 0, 1, 64'hDEAD_BEEF, 32'h3000);
    do_req("word_readback", 1'b0, SZ_WORD, 1'b0, 32'h3000, 64'h0, 1'b0, 64'hDEAD_BEEF,
           2, 1, 1, 0, 64'h0, 32'h3000);
    do_req("rmw_readback", 1'b0, SZ_WORD, 1'b0, 32'h1000, 64'h0, 1'b0, 64'h11AB_3344,
           2, 1, 1, 0, 64'h0, 32'h1000);
    do_req("mis_half", 1'b1, SZ_HALF, 1'b0, 32'h4001, 64'h1234, 1'b1, 64'h0,
           1, 0, 0, 0, 64'h0, 32'h0);
    do_req("mis_word", 1'b0, SZ_WORD, 1'b0, 32'h4002, 64'h0, 1'b1, 64'h0,
           1, 0, 0, 0, 64'h0, 32'h0);
    do_req("oversize", 1'b0, SZ_DWORD, 1'b0, 32'h4000, 64'h0, 1'b1, 64'h0,
           1, 0, 0, 0, 64'h0, 32'h0);

    // read ack held off three cycles during an RMW
    rd_wait = 3;
    do_req("rmw_wait", 1'b1, SZ_HALF, 1'b0, 32'h1000, 64'hFFFF_5566, 1'b0, 64'h0,
           6, 1, 4, 5, 64'h11AB_5566, 32'h1000);
    rd_wait = 0;

    // reset while the write strobe is pending
    wr_wait = 1000;
    resp_seen = 0;
    @(negedge clk);
    req_we = 1'b1; req_size = SZ_BYTE; req_signed = 1'b0; req_addr = 32'h1000;
    req_wdata = 64'h77; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int w = 0; w < 10 && !mwr32; w++) begin
      @(negedge clk);
      if (rv32) resp_seen++;
    end
    chk("abort_wr_seen", 64'(mwr32), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_wr_drop", 64'(mwr32), 64'd0);
    chk("abort_rd_low", 64'(mrd32), 64'd0);
    chk("abort_ready_low", 64'(ready32), 64'd0);
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      if (rv32) resp_seen++;
    end
    rst_n = 1'b1;
    wr_wait = 0;
    #1 chk("abort_ready_after", 64'(ready32), 64'd1);
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      if (rv32) resp_seen++;
    end
    chk("abort_no_resp", 64'(resp_seen), 64'd0);
    do_req("abort_readback", 1'b0, SZ_WORD, 1'b0, 32'h1000, 64'h0, 1'b0, 64'h11AB_5566,
           2, 1, 1, 0, 64'h0, 32'h1000);

    // 64-bit instance: byte sweep then wide loads
    @(negedge clk);
    sel64 = 1'b1;
    mem[32'h8000] = 64'hFFFF_FFFF_FFFF_FFFF;
    mem[32'h8008] = 64'hF000_0001_0000_0000;
    exp_word = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 8; i++) begin
      exp_word[8*i +: 8] = 8'h10 + 8'(i);
      do_req($sformatf("sweep_b%0d", i), 1'b1, SZ_BYTE, 1'b0, 32'h8000 + 32'(i),
             {56'hA5A5_A5A5_A5A5_A5, 8'h10 + 8'(i)}, 1'b0, 64'h0,
             3, 1, 1, 2, exp_word, 32'h8000);
    end
    do_req("sweep_dword", 1'b0, SZ_DWORD, 1'b1, 32'h8000, 64'h0, 1'b0,
           64'h1716_1514_1312_1110, 2, 1, 1, 0, 64'h0, 32'h8000);
    do_req("w64_word_s", 1'b0, SZ_WORD, 1'b1, 32'h800C, 64'h0, 1'b0,
           64'hFFFF_FFFF_F000_0001, 2, 1, 1, 0, 64'h0, 32'h8008);
    do_req("w64_dstore", 1'b1, SZ_DWORD, 1'b0, 32'h8010, 64'h0123_4567_89AB_CDEF, 1'b0,
           64'h0, 2, 0, 0, 1, 64'h0123_4567_89AB_CDEF, 32'h8010);
    do_req("w64_mis", 1'b0, SZ_DWORD, 1'b0, 32'h8004, 64'h0, 1'b1, 64'h0,
           1, 0, 0, 0, 64'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
